// File: rtl/dbus_req_issue.sv
// -----------------------------------------------------------------------------
// dbus_req_issue
// Initiator side of the data bus for the dual-issue pipeline. A pair of memory
// ops (slot 1 = older, slot 0 = younger) is latched from execute and turned
// into at most two single-port dbus requests, slot 1 first. Only one request is
// outstanding at a time. Store data is lane-replicated with matching byte
// strobes, misaligned ops are flagged and never issued, and raw load words are
// returned packed as {slot0 word, slot1 word}.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   in_valid             execute presents a pair (sampled in IDLE only)
//   slot_valid/write     per-slot op valid / store(1) or load(0); bit 1 = older
//   slot_addr/wdata      per-slot 32-bit fields, slot i at [32*i +: 32]
//   slot_size            per-slot size, slot i at [2*i +: 2] (3 acts as word)
//   req_*                dbus request channel (valid, addr, size, strobe,
//                        data, uncached)
//   addr_ok, data_ok     bus accepted address / bus completed request
//   resp_data            load data, valid with data_ok
//   rdata                {slot0 word, slot1 word}, valid with done
//   misalign, timeout    per-slot misalignment / watchdog fired, valid with done
//   stall                hold execute/memory registers
//   done                 one-cycle pulse when the pair has finished
// -----------------------------------------------------------------------------
module dbus_req_issue #(
  parameter int UNCACHED_BIT = 29,
  parameter int MAX_WAIT     = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [1:0]  slot_valid,
  input  logic [1:0]  slot_write,
  input  logic [63:0] slot_addr,
  input  logic [3:0]  slot_size,
  input  logic [63:0] slot_wdata,
  output logic        req_valid,
  output logic [31:0] req_addr,
  output logic [2:0]  req_size,
  output logic [3:0]  req_strobe,
  output logic [31:0] req_data,
  output logic        req_uncached,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] resp_data,
  output logic [63:0] rdata,
  output logic [1:0]  misalign,
  output logic        timeout,
  output logic        stall,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_A  = 3'd1,
    S_WAIT_A = 3'd2,
    S_REQ_B  = 3'd3,
    S_WAIT_B = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Half needs addr[0]=0, word (and size 3) needs addr[1:0]=0.
  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic res;
    case (size)
      2'd0:    res = 1'b0;
      2'd1:    res = lo[0];
      default: res = (lo != 2'b00);
    endcase
    return res;
  endfunction

  function automatic logic [3:0] f_strobe(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] res;
    case (size)
      2'd0:    res = 4'b0001 << lo;
      2'd1:    res = 4'b0011 << {lo[1], 1'b0};
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] res;
    case (size)
      2'd0:    res = {4{wd[7:0]}};
      2'd1:    res = {2{wd[15:0]}};
      default: res = wd;
    endcase
    return res;
  endfunction

  state_t      r_state;
  logic [1:0]  r_valid;
  logic [1:0]  r_write;
  logic [63:0] r_addr;
  logic [3:0]  r_size;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic [1:0]  r_misalign;
  logic        r_timeout;
  logic [7:0]  r_wdog;

  logic [1:0]  w_in_mis;
  logic [1:0]  w_in_need;
  logic [1:0]  w_need;
  logic        w_is_req;
  logic        w_is_wait;
  logic        w_slot_a;
  logic [31:0] w_act_addr;
  logic [1:0]  w_act_size;
  logic        w_act_write;
  logic [31:0] w_act_wdata;
  logic        w_complete;
  logic        w_wdog_fire;

  // Only valid ops can be misaligned; an invalid slot is simply skipped.
  assign w_in_mis[1] = slot_valid[1] & f_misaligned(slot_size[3:2], slot_addr[33:32]);
  assign w_in_mis[0] = slot_valid[0] & f_misaligned(slot_size[1:0], slot_addr[1:0]);
  assign w_in_need   = slot_valid & ~w_in_mis;
  assign w_need      = r_valid & ~r_misalign;

  assign w_is_req  = (r_state == S_REQ_A) || (r_state == S_REQ_B);
  assign w_is_wait = (r_state == S_WAIT_A) || (r_state == S_WAIT_B);
  assign w_slot_a  = (r_state == S_REQ_A) || (r_state == S_WAIT_A);

  // REQ_A/WAIT_A serve slot 1 (older); REQ_B/WAIT_B serve slot 0.
  assign w_act_addr  = w_slot_a ? r_addr[63:32]  : r_addr[31:0];
  assign w_act_size  = w_slot_a ? r_size[3:2]    : r_size[1:0];
  assign w_act_write = w_slot_a ? r_write[1]     : r_write[0];
  assign w_act_wdata = w_slot_a ? r_wdata[63:32] : r_wdata[31:0];

  assign w_complete  = (w_is_req & addr_ok & data_ok) | (w_is_wait & data_ok);
  // Counter is 0 in the first busy cycle, so this fires on the MAX_WAIT-th cycle.
  assign w_wdog_fire = (r_wdog == 8'(MAX_WAIT - 1));

  assign req_valid    = w_is_req;
  assign req_addr     = w_is_req ? w_act_addr : 32'h0000_0000;
  assign req_size     = w_is_req ? {1'b0, w_act_size} : 3'b000;
  assign req_strobe   = (w_is_req & w_act_write) ? f_strobe(w_act_size, w_act_addr[1:0]) : 4'b0000;
  assign req_data     = (w_is_req & w_act_write) ? f_wdata(w_act_size, w_act_wdata) : 32'h0000_0000;
  assign req_uncached = req_addr[UNCACHED_BIT];

  assign rdata    = r_rdata;
  assign misalign = r_misalign;
  assign timeout  = r_timeout;
  assign done     = (r_state == S_DONE);
  assign stall    = w_is_req | w_is_wait | ((r_state == S_IDLE) & in_valid);

  // Sequencer: latch the pair, issue slot 1 then slot 0, collect load data, watchdog.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_valid    <= 2'b00;
      r_write    <= 2'b00;
      r_addr     <= 64'h0;
      r_size     <= 4'h0;
      r_wdata    <= 64'h0;
      r_rdata    <= 64'h0;
      r_misalign <= 2'b00;
      r_timeout  <= 1'b0;
      r_wdog     <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_valid    <= slot_valid;
            r_write    <= slot_write;
            r_addr     <= slot_addr;
            r_size     <= slot_size;
            r_wdata    <= slot_wdata;
            r_misalign <= w_in_mis;
            r_rdata    <= 64'h0;
            r_timeout  <= 1'b0;
            r_wdog     <= 8'd0;
            if (w_in_need[1]) begin
              r_state <= S_REQ_A;
            end else if (w_in_need[0]) begin
              r_state <= S_REQ_B;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ_A, S_WAIT_A, S_REQ_B, S_WAIT_B: begin
          if (w_complete) begin
            if (!w_act_write) begin
              if (w_slot_a) begin
                r_rdata[31:0] <= resp_data;
              end else begin
                r_rdata[63:32] <= resp_data;
              end
            end
            if (w_slot_a && w_need[0]) begin
              r_state <= S_REQ_B;
              r_wdog  <= 8'd0;
            end else begin
              r_state <= S_DONE;
            end
          end else if (w_wdog_fire) begin
            // Abandon this request and any remaining slot.
            r_timeout <= 1'b1;
            r_wdog    <= r_wdog + 8'd1;
            r_state   <= S_DONE;
          end else begin
            r_wdog <= r_wdog + 8'd1;
            if (w_is_req && addr_ok) begin
              r_state <= w_slot_a ? S_WAIT_A : S_WAIT_B;
            end else begin
              r_state <= r_state;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_req_issue.sv
module tb_dbus_req_issue;
  localparam int MAX_WAIT = 255;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [1:0]  slot_valid;
  logic [1:0]  slot_write;
  logic [63:0] slot_addr;
  logic [3:0]  slot_size;
  logic [63:0] slot_wdata;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [3:0]  req_strobe;
  logic [31:0] req_data;
  logic        req_uncached;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] resp_data;
  logic [63:0] rdata;
  logic [1:0]  misalign;
  logic        timeout;
  logic        stall;
  logic        done;

  dbus_req_issue #(.UNCACHED_BIT(29), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid),
    .slot_valid(slot_valid), .slot_write(slot_write), .slot_addr(slot_addr),
    .slot_size(slot_size), .slot_wdata(slot_wdata),
    .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
    .req_strobe(req_strobe), .req_data(req_data), .req_uncached(req_uncached),
    .addr_ok(addr_ok), .data_ok(data_ok), .resp_data(resp_data),
    .rdata(rdata), .misalign(misalign), .timeout(timeout),
    .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic        unc;
  } req_t;

  int n_pass  = 0;
  int n_total = 0;

  req_t        obs_q[$];
  logic [31:0] sent_q[$];
  logic [31:0] preset_q[$];
  int          obs_lat;
  bit          obs_done;
  logic [63:0] obs_rdata;
  logic [1:0]  obs_mis;
  logic        obs_to;
  logic        obs_stall_done;
  int          obs_unstable;
  int          obs_stall_low;
  int          obs_wait_req;
  int          obs_accept_stall_bad;

  task automatic set_slot(input int i, input logic v, input logic w,
                          input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    slot_valid[i]         = v;
    slot_write[i]         = w;
    slot_addr[32*i +: 32] = a;
    slot_size[2*i +: 2]   = sz;
    slot_wdata[32*i +: 32] = d;
  endtask

  // Reference model: misalignment from the byte count of each access.
  function automatic logic [1:0] m_mis();
    logic [1:0] m;
    for (int i = 0; i < 2; i++) begin
      int nb;
      logic [1:0] sz;
      sz = slot_size[2*i +: 2];
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      m[i] = slot_valid[i] && ((slot_addr[32*i +: 32] % nb) != 0);
    end
    return m;
  endfunction

  // Reference model: the bus request a slot should produce.
  function automatic req_t m_req(input int i);
    req_t r;
    int nb;
    int off;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0] sz;
    a  = slot_addr[32*i +: 32];
    wd = slot_wdata[32*i +: 32];
    sz = slot_size[2*i +: 2];
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    r.addr   = a;
    r.size   = {1'b0, sz};
    r.unc    = a[29];
    r.strobe = 4'b0000;
    r.data   = 32'h0;
    if (slot_write[i]) begin
      for (int k = 0; k < 4; k++) begin
        if (k >= off && k < off + nb) r.strobe[k] = 1'b1;
        r.data[8*k +: 8] = wd[8*(k % nb) +: 8];
      end
    end
    return r;
  endfunction

  // Present the current slots for one pair and act as the bus until done.
  task automatic run_pair(input int a_dly, input int d_dly, input bit hang);
    int lat;
    int phase;
    int cnt;
    int dcnt;
    bit fresh;
    req_t cur;
    obs_q.delete();
    sent_q.delete();
    obs_unstable = 0; obs_stall_low = 0; obs_wait_req = 0; obs_accept_stall_bad = 0;
    obs_done = 1'b0; obs_rdata = 64'h0; obs_mis = 2'b00; obs_to = 1'b0; obs_stall_done = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    if (stall !== 1'b1) obs_accept_stall_bad = 1;
    @(posedge clk);
    lat = 0; phase = 0; cnt = 0; dcnt = 0; fresh = 1'b1;
    while (lat < 600) begin
      @(negedge clk);
      lat++;
      in_valid  = 1'b0;
      addr_ok   = 1'b0;
      data_ok   = 1'b0;
      resp_data = $urandom;
      if (done === 1'b1) begin
        obs_done = 1'b1; obs_rdata = rdata; obs_mis = misalign;
        obs_to = timeout; obs_stall_done = stall;
        break;
      end
      if (stall !== 1'b1) obs_stall_low++;
      cur = '{addr: req_addr, size: req_size, strobe: req_strobe, data: req_data, unc: req_uncached};
      if (phase == 0) begin
        if (req_valid === 1'b1) begin
          if (fresh) begin
            obs_q.push_back(cur);
            fresh = 1'b0;
            cnt = 0;
          end else if (cur !== obs_q[$]) begin
            obs_unstable++;
          end
          if (cnt == a_dly) begin
            addr_ok = 1'b1;
            fresh = 1'b1;
            if (d_dly == 0 && !hang) begin
              data_ok = 1'b1;
              resp_data = (preset_q.size() > 0) ? preset_q.pop_front() : $urandom;
              sent_q.push_back(resp_data);
            end else begin
              phase = 1;
              dcnt = 1;
            end
          end else begin
            cnt++;
          end
        end
      end else begin
        if (req_valid !== 1'b0) obs_wait_req++;
        if (!hang) begin
          if (dcnt == d_dly) begin
            data_ok = 1'b1;
            resp_data = (preset_q.size() > 0) ? preset_q.pop_front() : $urandom;
            sent_q.push_back(resp_data);
            phase = 0;
          end else begin
            dcnt++;
          end
        end
      end
    end
    obs_lat = lat;
    addr_ok = 1'b0;
    data_ok = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; resp_data = 32'h0;
    slot_valid = 2'b00; slot_write = 2'b00; slot_addr = 64'h0; slot_size = 4'h0; slot_wdata = 64'h0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({req_valid, stall, done, timeout, misalign} !== 6'b0) $display("FAIL reset_ctrl got %b exp 0", {req_valid, stall, done, timeout, misalign});
    else n_pass++;
    n_total++;
    if (rdata !== 64'h0) $display("FAIL reset_rdata got %h exp 0", rdata); else n_pass++;
    n_total++;
    if ({req_addr, req_strobe, req_data, req_size} !== 71'h0) $display("FAIL reset_req got %h/%h/%h exp 0", req_addr, req_strobe, req_data);
    else n_pass++;
    resetn = 1'b1;
  endtask

  task automatic test_single_load();
    set_slot(1, 1'b1, 1'b0, 32'h8000_0010, 2'd2, 32'h5555_5555);
    set_slot(0, 1'b0, 1'b1, 32'h0000_0044, 2'd2, 32'h6666_6666);
    preset_q.push_back(32'hDEAD_BEEF);
    run_pair(0, 0, 1'b0);
    n_total++;
    if (obs_q.size() != 1) $display("FAIL lw_req_count got %0d exp 1", obs_q.size());
    else begin
      n_pass++;
      n_total++;
      if (obs_q[0] !== m_req(1) || obs_q[0].strobe !== 4'b0000 || obs_q[0].size !== 3'd2)
        $display("FAIL lw_req got %h exp %h", obs_q[0], m_req(1));
      else n_pass++;
    end
    n_total++;
    if (obs_lat != 2 || !obs_done) $display("FAIL lw_latency got %0d exp 2", obs_lat); else n_pass++;
    n_total++;
    if (obs_rdata !== 64'h0000_0000_DEAD_BEEF) $display("FAIL lw_rdata got %h exp 00000000deadbeef", obs_rdata); else n_pass++;
    n_total++;
    if (obs_stall_done !== 1'b0 || obs_accept_stall_bad != 0) $display("FAIL lw_stall done_stall %b accept_bad %0d exp 0/0", obs_stall_done, obs_accept_stall_bad);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if (rdata !== 64'h0000_0000_DEAD_BEEF || done !== 1'b0) $display("FAIL lw_hold got %h done %b exp deadbeef/0", rdata, done); else n_pass++;
  endtask

  task automatic test_store_pair();
    set_slot(1, 1'b1, 1'b1, 32'h0000_1003, 2'd0, 32'h0000_0012);
    set_slot(0, 1'b1, 1'b1, 32'h0000_2006, 2'd1, 32'h0000_ABCD);
    run_pair(0, 0, 1'b0);
    n_total++;
    if (obs_q.size() != 2) $display("FAIL st_req_count got %0d exp 2", obs_q.size());
    else begin
      n_pass++;
      n_total++;
      if (obs_q[0].data !== 32'h1212_1212 || obs_q[0].strobe !== 4'b1000)
        $display("FAIL st_sb got %h/%b exp 12121212/1000", obs_q[0].data, obs_q[0].strobe);
      else n_pass++;
      n_total++;
      if (obs_q[1].data !== 32'hABCD_ABCD || obs_q[1].strobe !== 4'b1100 || obs_q[1].addr !== 32'h0000_2006)
        $display("FAIL st_sh got %h/%b exp abcdabcd/1100", obs_q[1].data, obs_q[1].strobe);
      else n_pass++;
    end
    n_total++;
    if (obs_lat != 3 || obs_rdata !== 64'h0) $display("FAIL st_done got lat %0d rdata %h exp 3/0", obs_lat, obs_rdata); else n_pass++;
  endtask

  task automatic test_misalign();
    set_slot(1, 1'b0, 1'b0, 32'h0000_0300, 2'd2, 32'h0);
    set_slot(0, 1'b1, 1'b0, 32'h0000_0402, 2'd2, 32'h0);
    run_pair(0, 0, 1'b0);
    n_total++;
    if (obs_mis !== 2'b01) $display("FAIL mis_flag got %b exp 01", obs_mis); else n_pass++;
    n_total++;
    if (obs_q.size() != 0 || obs_lat != 1 || obs_rdata !== 64'h0)
      $display("FAIL mis_skip got reqs %0d lat %0d rdata %h exp 0/1/0", obs_q.size(), obs_lat, obs_rdata);
    else n_pass++;
  endtask

  task automatic test_delayed();
    set_slot(1, 1'b1, 1'b0, 32'h0000_0120, 2'd2, 32'h0);
    set_slot(0, 1'b0, 1'b0, 32'h0000_0000, 2'd0, 32'h0);
    run_pair(3, 2, 1'b0);
    n_total++;
    if (obs_unstable != 0 || obs_stall_low != 0 || obs_wait_req != 0)
      $display("FAIL dly_stable got unstable %0d stall_low %0d wait_req %0d exp 0/0/0", obs_unstable, obs_stall_low, obs_wait_req);
    else n_pass++;
    n_total++;
    if (obs_lat != 7) $display("FAIL dly_latency got %0d exp 7", obs_lat); else n_pass++;
    n_total++;
    if (sent_q.size() != 1 || obs_rdata !== {32'h0, sent_q[0]}) $display("FAIL dly_rdata got %h exp resp at data_ok", obs_rdata); else n_pass++;
  endtask

  task automatic test_timeout();
    set_slot(1, 1'b1, 1'b0, 32'hA000_0000, 2'd2, 32'h0);
    set_slot(0, 1'b1, 1'b0, 32'h0000_0040, 2'd2, 32'h0);
    run_pair(0, 0, 1'b1);
    n_total++;
    if (obs_q.size() != 1) $display("FAIL to_req_count got %0d exp 1", obs_q.size());
    else begin
      n_pass++;
      n_total++;
      if (obs_q[0].unc !== 1'b1) $display("FAIL to_uncached got %b exp 1", obs_q[0].unc); else n_pass++;
    end
    n_total++;
    if (!obs_done || obs_to !== 1'b1 || obs_lat != MAX_WAIT + 1)
      $display("FAIL to_fire got done %0d timeout %b lat %0d exp 1/1/%0d", obs_done, obs_to, obs_lat, MAX_WAIT + 1);
    else n_pass++;
    n_total++;
    if (obs_rdata !== 64'h0) $display("FAIL to_rdata got %h exp 0", obs_rdata); else n_pass++;
  endtask

  task automatic test_reset_wait_b();
    set_slot(1, 1'b1, 1'b0, 32'h0000_0100, 2'd2, 32'h0);
    set_slot(0, 1'b1, 1'b0, 32'h0000_0200, 2'd2, 32'h0);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    addr_ok = 1'b1; data_ok = 1'b1; resp_data = 32'h1111_2222;
    @(negedge clk);
    addr_ok = 1'b1; data_ok = 1'b0; resp_data = 32'h0;
    @(negedge clk);
    addr_ok = 1'b0;
    n_total++;
    if (req_valid !== 1'b0 || stall !== 1'b1 || rdata !== 64'h0000_0000_1111_2222)
      $display("FAIL rst_pre got valid %b stall %b rdata %h exp 0/1/11112222", req_valid, stall, rdata);
    else n_pass++;
    #2 resetn = 1'b0;
    #1;
    n_total++;
    if ({req_valid, stall, done, timeout, misalign, rdata, req_addr} !== 102'h0)
      $display("FAIL rst_async got valid %b stall %b rdata %h addr %h exp 0", req_valid, stall, rdata, req_addr);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    data_ok = 1'b1; resp_data = 32'hFFFF_0000;
    @(negedge clk);
    data_ok = 1'b0;
    n_total++;
    if (done !== 1'b0 || req_valid !== 1'b0 || stall !== 1'b0 || rdata !== 64'h0)
      $display("FAIL rst_stray got done %b valid %b stall %b rdata %h exp 0", done, req_valid, stall, rdata);
    else n_pass++;
    set_slot(0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
    run_pair(0, 0, 1'b0);
    n_total++;
    if (obs_lat != 2 || sent_q.size() != 1 || obs_rdata !== {32'h0, sent_q[0]})
      $display("FAIL rst_recover got lat %0d rdata %h exp 2", obs_lat, obs_rdata);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      req_t exp_q[$];
      logic [1:0] emis;
      logic [1:0] need;
      logic [63:0] erd;
      int a_dly;
      int d_dly;
      int idx;
      for (int s = 0; s < 2; s++) begin
        logic [31:0] a;
        a = $urandom;
        set_slot(s, 1'($urandom), 1'($urandom), a, 2'($urandom), $urandom);
      end
      a_dly = $urandom_range(0, 3);
      d_dly = $urandom_range(0, 3);
      run_pair(a_dly, d_dly, 1'b0);
      emis = m_mis();
      need = slot_valid & ~emis;
      erd = 64'h0;
      idx = 0;
      for (int s = 1; s >= 0; s--) begin
        if (need[s]) begin
          exp_q.push_back(m_req(s));
          if (!slot_write[s] && idx < sent_q.size()) begin
            if (s == 1) erd[31:0] = sent_q[idx];
            else erd[63:32] = sent_q[idx];
          end
          idx++;
        end
      end
      n_total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL rnd_req_count it %0d got %0d exp %0d", it, obs_q.size(), exp_q.size());
      else begin
        n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
          n_total++;
          if (obs_q[k] !== exp_q[k]) $display("FAIL rnd_req it %0d #%0d got %h exp %h", it, k, obs_q[k], exp_q[k]);
          else n_pass++;
        end
      end
      n_total++;
      if (obs_mis !== emis || obs_to !== 1'b0) $display("FAIL rnd_flags it %0d got mis %b to %b exp %b/0", it, obs_mis, obs_to, emis);
      else n_pass++;
      n_total++;
      if (obs_rdata !== erd) $display("FAIL rnd_rdata it %0d got %h exp %h", it, obs_rdata, erd); else n_pass++;
      n_total++;
      if (obs_lat != 1 + exp_q.size() * (a_dly + 1 + d_dly))
        $display("FAIL rnd_latency it %0d got %0d exp %0d", it, obs_lat, 1 + exp_q.size() * (a_dly + 1 + d_dly));
      else n_pass++;
      n_total++;
      if (obs_unstable != 0 || obs_stall_low != 0 || obs_wait_req != 0 || obs_accept_stall_bad != 0)
        $display("FAIL rnd_handshake it %0d got %0d/%0d/%0d/%0d exp 0", it, obs_unstable, obs_stall_low, obs_wait_req, obs_accept_stall_bad);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store_pair();
    test_misalign();
    test_delayed();
    test_timeout();
    test_reset_wait_b();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
